// File: rtl/atm_pkg.sv
// Shared types and widths for the ATM session sequencer.
package atm_pkg;

  localparam int unsigned PIN_W   = 16;
  localparam int unsigned AMT_W   = 8;
  localparam int unsigned BAL_W   = 16;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned TRIES_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_PIN      = 3'd1,
    ST_MENU     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_EJECT    = 3'd5,
    ST_LOCKED   = 3'd6
  } atm_state_t;

endpackage

// File: rtl/atm_cycle_timer.sv
// Loadable down-counter; done_c flags the edge on which the count reaches zero.
module atm_cycle_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == W'(1));

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card presence, PIN retries with lockout, balance-checked dispense.
// Optional PIN/MENU inactivity timeout is compiled in with ATM_SESSION_TIMEOUT_EN.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCK_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               card_in,
  input  logic               pin_valid,
  input  logic [PIN_W-1:0]   pin,
  input  logic [PIN_W-1:0]   ref_pin,
  input  logic               amt_valid,
  input  logic [AMT_W-1:0]   amount,
  input  logic               bal_load,
  input  logic [BAL_W-1:0]   bal_in,
  input  logic               disp_ack,
  output logic               disp_req,
  output logic [AMT_W-1:0]   disp_amount,
  output logic               granted,
  output logic               denied,
  output logic               locked,
  output logic               card_eject,
  output logic [BAL_W-1:0]   balance,
  output logic [STATE_W-1:0] state
);

`ifdef ATM_SESSION_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int unsigned TMR_MAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  atm_state_t         state_r;
  logic [BAL_W-1:0]   balance_r;
  logic [AMT_W-1:0]   disp_amount_r;
  logic [AMT_W-1:0]   amt_r;
  logic [TRIES_W-1:0] tries_r;
  logic               granted_r;
  logic               denied_r;

  logic [TRIES_W-1:0] tries_inc_c;
  logic               pin_match_c;
  logic               lock_now_c;
  logic               amt_reject_c;
  logic               tmr_load_c;
  logic [TMR_W-1:0]   tmr_val_c;
  logic               tmr_done_c;

  assign tries_inc_c  = tries_r + TRIES_W'(1);
  assign pin_match_c  = (pin == ref_pin);
  assign lock_now_c   = (tries_inc_c == TRIES_W'(MAX_TRIES));
  assign amt_reject_c = (amt_r == '0) || (BAL_W'(amt_r) > balance_r);

  // Timer reloads: lockout on LOCKED entry; timeout on PIN/MENU entry and on strobes.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = TMR_W'(TIMEOUT_CYCLES);
    case (state_r)
      ST_IDLE:  tmr_load_c = TMO_EN && card_in;
      ST_PIN: begin
        if (card_in && pin_valid) begin
          if (!pin_match_c && lock_now_c) begin
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(LOCK_CYCLES);
          end else begin
            tmr_load_c = TMO_EN;
          end
        end
      end
      ST_MENU:  tmr_load_c = TMO_EN && card_in && amt_valid;
      ST_CHECK: tmr_load_c = TMO_EN && amt_reject_c;
      default:  tmr_load_c = 1'b0;
    endcase
  end

  atm_cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      balance_r     <= '0;
      disp_amount_r <= '0;
      amt_r         <= '0;
      tries_r       <= '0;
      granted_r     <= 1'b0;
      denied_r      <= 1'b0;
    end else begin
      granted_r <= 1'b0;
      denied_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bal_load) balance_r <= bal_in;
          if (card_in) begin
            tries_r <= '0;
            state_r <= ST_PIN;
          end
        end
        ST_PIN: begin
          if (!card_in) begin
            state_r <= ST_IDLE;
          end else if (pin_valid) begin
            if (pin_match_c) begin
              granted_r <= 1'b1;
              state_r   <= ST_MENU;
            end else begin
              tries_r  <= tries_inc_c;
              denied_r <= 1'b1;
              if (lock_now_c) state_r <= ST_LOCKED;
            end
          end else if (TMO_EN && tmr_done_c) begin
            state_r <= ST_EJECT;
          end
        end
        ST_MENU: begin
          if (!card_in) begin
            state_r <= ST_IDLE;
          end else if (amt_valid) begin
            amt_r   <= amount;
            state_r <= ST_CHECK;
          end else if (TMO_EN && tmr_done_c) begin
            state_r <= ST_EJECT;
          end
        end
        ST_CHECK: begin
          if (amt_reject_c) begin
            denied_r <= 1'b1;
            state_r  <= ST_MENU;
          end else begin
            balance_r     <= balance_r - BAL_W'(amt_r);
            disp_amount_r <= amt_r;
            state_r       <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: if (disp_ack) state_r <= ST_EJECT;
        ST_EJECT:    if (!card_in) state_r <= ST_IDLE;
        ST_LOCKED:   if (tmr_done_c) state_r <= ST_EJECT;
        default:     state_r <= ST_IDLE;
      endcase
    end
  end

  assign disp_req    = (state_r == ST_DISPENSE);
  assign locked      = (state_r == ST_LOCKED);
  assign card_eject  = (state_r == ST_EJECT);
  assign state       = state_r;
  assign balance     = balance_r;
  assign disp_amount = disp_amount_r;
  assign granted     = granted_r;
  assign denied      = denied_r;

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session sequencer for the ATM front end: it tracks card presence, verifies the entered PIN with a bounded retry count, and checks each withdrawal request against a held balance. Approved withdrawals go to the cash dispenser over a req/ack handshake. It sits between the keypad/card-reader inputs and the dispenser, replacing the free-running PIN/amount FSM as the block that owns the session.

## Interface
- MAX_TRIES, 3, wrong-PIN attempts before lockout (1..7)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (≥1)
- TIMEOUT_CYCLES, 5000, inactivity limit in PIN/MENU (used only with timeout compiled in)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- card_in  in  1  card present (level)
- pin_valid  in  1  one-cycle strobe: `pin` holds a complete entry
- pin  in  16  entered PIN, 4 BCD digits
- ref_pin  in  16  stored PIN for the inserted card, stable while card_in=1
- amt_valid  in  1  one-cycle strobe: `amount` holds a request
- amount  in  8  requested withdrawal, unsigned units
- bal_load  in  1  load `bal_in` into balance
- bal_in  in  16  account balance
- disp_ack  in  1  dispenser completion
- disp_req  out  1  dispense request
- disp_amount  out  8  amount to dispense, stable while disp_req=1
- granted  out  1  one-cycle pulse: PIN accepted
- denied  out  1  one-cycle pulse: PIN wrong or amount rejected
- locked  out  1  high in LOCKED
- card_eject  out  1  high in EJECT
- balance  out  16  current balance
- state  out  3  current state encoding

## Operation
- States: IDLE=0, PIN=1, MENU=2, CHECK=3, DISPENSE=4, EJECT=5, LOCKED=6. Code 7 is unreachable; if entered, it returns to IDLE on the next edge.
- IDLE
  - card_in=1 → PIN, with the try counter cleared.
  - bal_load is honoured only in IDLE and ignored in all other states.
- PIN
  - card_in=0 → IDLE. Card removal outranks a same-cycle pin_valid.
  - pin_valid with pin==ref_pin → MENU and pulse granted.
  - pin_valid with a mismatch → increment tries and pulse denied. If the new count equals MAX_TRIES → LOCKED; otherwise stay in PIN.
- MENU
  - card_in=0 → IDLE (card removal wins).
  - amt_valid → CHECK, with amount latched.
- CHECK (one cycle)
  - Latched amount is 0, or greater than balance after zero-extension → pulse denied, return to MENU.
  - Otherwise → balance -= amount, disp_amount = amount, go to DISPENSE. Underflow cannot occur.
- DISPENSE
  - disp_req=1 until disp_ack is sampled high, then → EJECT.
  - card_in is ignored.
  - disp_ack outside DISPENSE is ignored.
- EJECT: card_eject=1 until card_in=0, then → IDLE.
- LOCKED
  - locked=1 and card_eject=0 (card retained).
  - After LOCK_CYCLES cycles → EJECT.
  - card_in and all strobes are ignored.
- Reset values: state=IDLE, balance=0, disp_amount=0, tries=0, timer=0, and every 1-bit output 0.

## Timing
- disp_req, locked, card_eject and state are decoded from the state register. granted and denied are registered and assert on the same edge as the state change they report.
- pin_valid → granted/denied: visible 1 cycle after the strobe cycle.
- amt_valid → disp_req high: 2 edges (MENU→CHECK→DISPENSE). A rejected amount pulses denied 2 edges after amt_valid.
- The balance update is visible on the same edge that disp_req rises.
- disp_ack sampled high at edge n → disp_req low after edge n. The minimum DISPENSE residency is 1 cycle.
- LOCKED lasts exactly LOCK_CYCLES cycles: the counter is loaded on entry and the exit is taken on the edge where it reaches 0.
- Reset in any state, including mid-DISPENSE, takes effect on the next edge. disp_req drops without waiting for disp_ack.

## Configuration
- ATM_SESSION_TIMEOUT_EN defined
  - Timer reloads with TIMEOUT_CYCLES on entry to PIN or MENU, and on every pin_valid or amt_valid.
  - Reaching 0 in PIN or MENU → EJECT, with no denied pulse.
  - Card removal still takes priority.
- ATM_SESSION_TIMEOUT_EN undefined: PIN and MENU wait indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- atm_pkg holds:
  - the state enum with its 3-bit encodings;
  - the PIN width (16), amount width (8) and balance width (16) constants.
- Sub-module atm_cycle_timer: a down-counter with load value, load strobe and done output. The lockout and the timeout share one instance, since they are never active together. Timer width is sized for the larger of LOCK_CYCLES and TIMEOUT_CYCLES.

## Test plan
- Balance load and PIN accept: reset, bal_load with bal_in=500, card_in=1, pin=0x1234 matching ref_pin → granted pulse, state=MENU.
- Lockout: 3 wrong PINs → 3 denied pulses, then LOCKED. locked=1 for exactly 1000 cycles, then EJECT; card_in=0 → IDLE.
- Withdrawal and rejection:
  - From MENU with balance 500, amount=200 and disp_ack held off for 5 cycles → disp_req high 2 edges after amt_valid, disp_amount=200, balance=300; ack → EJECT.
  - From MENU with balance=100, amount=101 → denied, back to MENU, balance unchanged. amount=0 → denied.
- Simultaneous events: card_in falls in the same cycle as a correct pin_valid → IDLE, no granted pulse. bal_load during MENU → balance unchanged.
- Reset mid-DISPENSE → next cycle disp_req=0, state=IDLE, balance=0.
- Timeout, with ATM_SESSION_TIMEOUT_EN and TIMEOUT_CYCLES=50: idle in MENU for 50 cycles → EJECT. A strobe at cycle 49 restarts the count.
